// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end: slot layout,
// reset fetch address and the sequential PC step.
package if_pkg;

    // Width of the PC and instruction fields held in each slot.
    localparam int unsigned IF_XLEN = 32;

    // Default first fetch address after reset.
    localparam logic [IF_XLEN-1:0] IF_RESET_PC = 32'h0000_0000;

    // Byte distance between sequential fetch addresses.
    localparam int unsigned IF_PC_INC = 4;

    // One in-order queue entry: PC is known at request time, the
    // instruction arrives later and sets filled.
    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] inst;
        logic               filled;
    } if_slot_t;

endpackage

// File: rtl/if_slot_queue.sv
// In-order slot queue for the fetch front end. A slot is allocated when a
// request is accepted, filled when its response returns and popped by ID.
// Pointers carry one extra MSB so that full and empty are distinguishable.
module if_slot_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               alloc_en,
    input  logic [IF_XLEN-1:0] alloc_pc,
    input  logic               fill_en,
    input  logic [IF_XLEN-1:0] fill_inst,
    input  logic               pop_en,
    output logic               full,
    output logic               empty,
    output if_slot_t           head
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    if_slot_t    slots_r [DEPTH];
    logic [AW:0] alloc_ptr_r;
    logic [AW:0] fill_ptr_r;
    logic [AW:0] head_ptr_r;
    logic [AW:0] used_s;

    // Occupancy flags and head view derived from the pointers.
    always_comb begin
        used_s = alloc_ptr_r - head_ptr_r;
        full   = (used_s == DEPTH_W);
        empty  = (alloc_ptr_r == head_ptr_r);
        head   = slots_r[head_ptr_r[AW-1:0]];
    end

    // Pointer advance; clear rewinds all three pointers to an empty queue.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            alloc_ptr_r <= '0;
            fill_ptr_r  <= '0;
            head_ptr_r  <= '0;
        end else begin
            if (alloc_en) begin
                alloc_ptr_r <= alloc_ptr_r + PTR_ONE;
            end
            if (fill_en) begin
                fill_ptr_r <= fill_ptr_r + PTR_ONE;
            end
            if (pop_en) begin
                head_ptr_r <= head_ptr_r + PTR_ONE;
            end
        end
    end

    // Slot contents; allocate, fill and pop always touch distinct slots.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots_r[i] <= '0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots_r[i].filled <= 1'b0;
            end
        end else begin
            if (alloc_en) begin
                slots_r[alloc_ptr_r[AW-1:0]].pc     <= alloc_pc;
                slots_r[alloc_ptr_r[AW-1:0]].inst   <= '0;
                slots_r[alloc_ptr_r[AW-1:0]].filled <= 1'b0;
            end
            if (fill_en) begin
                slots_r[fill_ptr_r[AW-1:0]].inst   <= fill_inst;
                slots_r[fill_ptr_r[AW-1:0]].filled <= 1'b1;
            end
            if (pop_en) begin
                slots_r[head_ptr_r[AW-1:0]].filled <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential fetch PC generation, a bounded
// number of in-flight memory requests, in-order buffering of returned
// instructions and a redirect that retargets fetch and discards stale
// responses. Define IF_PERF_CNT_EN to add the perf_fetched / perf_dropped
// event counters and their ports.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned      XLEN     = IF_XLEN,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      MAX_OUT  = 2,
    parameter logic [XLEN-1:0]  RESET_PC = IF_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [XLEN-1:0] id_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    // The slot layout is fixed by the package, so XLEN must match it.
    if (XLEN != IF_XLEN) begin : g_xlen_check
        $error("if_fetch_queue: XLEN must equal if_pkg::IF_XLEN");
    end

    // One spare bit so that out_cnt + drop_cnt never overflows.
    localparam int unsigned     CW        = $clog2(MAX_OUT + 1) + 1;
    localparam logic [CW-1:0]   MAX_OUT_W = MAX_OUT[CW-1:0];
    localparam logic [XLEN-1:0] PC_INC_W  = IF_PC_INC[XLEN-1:0];

    logic [XLEN-1:0] fetch_pc_r;
    logic [CW-1:0]   out_cnt_r;
    logic [CW-1:0]   drop_cnt_r;

    logic            full_s;
    logic            empty_s;
    if_slot_t        head_s;
    logic            issue_s;
    logic            req_hs_s;
    logic            rsp_live_s;
    logic            rsp_drop_s;
    logic            head_ok_s;
    logic            pop_s;
    logic [CW-1:0]   req_inc_s;
    logic [CW-1:0]   live_dec_s;
    logic [CW-1:0]   drop_dec_s;
    logic [CW-1:0]   rsp_dec_s;

    if_slot_queue #(
        .DEPTH (DEPTH)
    ) u_slot_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .alloc_en  (req_hs_s),
        .alloc_pc  (fetch_pc_r),
        .fill_en   (rsp_live_s),
        .fill_inst (imem_rsp_data),
        .pop_en    (pop_s),
        .full      (full_s),
        .empty     (empty_s),
        .head      (head_s)
    );

    // Issue, response routing and ID handshake decisions for this cycle.
    always_comb begin
        issue_s    = rst && !full_s && ((out_cnt_r + drop_cnt_r) < MAX_OUT_W)
                     && !redirect_valid;
        req_hs_s   = issue_s && imem_req_ready;
        rsp_drop_s = imem_rsp_valid && (drop_cnt_r != '0);
        rsp_live_s = imem_rsp_valid && (drop_cnt_r == '0);
        head_ok_s  = head_s.filled && !empty_s;
        pop_s      = head_ok_s && !redirect_valid && id_ready;
        req_inc_s  = CW'(req_hs_s);
        live_dec_s = CW'(rsp_live_s);
        drop_dec_s = CW'(rsp_drop_s);
        rsp_dec_s  = CW'(imem_rsp_valid);
    end

    // Output views; the ID fields read as zero whenever no head is offered.
    always_comb begin
        imem_req_valid = issue_s;
        imem_req_addr  = fetch_pc_r;
        id_valid       = head_ok_s && !redirect_valid;
        if (id_valid) begin
            id_pc   = head_s.pc;
            id_pc4  = head_s.pc + PC_INC_W;
            id_inst = head_s.inst;
        end else begin
            id_pc   = '0;
            id_pc4  = '0;
            id_inst = '0;
        end
    end

    // Fetch PC and in-flight accounting; a redirect turns every live
    // request into one whose response must be discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            out_cnt_r  <= '0;
            drop_cnt_r <= '0;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            out_cnt_r  <= '0;
            drop_cnt_r <= drop_cnt_r + out_cnt_r + req_inc_s - rsp_dec_s;
        end else begin
            if (req_hs_s) begin
                fetch_pc_r <= fetch_pc_r + PC_INC_W;
            end
            out_cnt_r  <= out_cnt_r + req_inc_s - live_dec_s;
            drop_cnt_r <= drop_cnt_r - drop_dec_s;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Event counters: ID handshakes, and responses that never enter the queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched <= 32'd0;
            perf_dropped <= 32'd0;
        end else begin
            if (pop_s) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (rsp_drop_s || (imem_rsp_valid && redirect_valid)) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch front end replacing the single-register PC stage. Generates sequential fetch addresses, issues them to instruction memory over a valid/ready request channel with up to MAX_OUT requests in flight, and buffers returned instructions with their PCs in a DEPTH-entry in-order slot queue. The queue feeds ID through a valid/ready handshake. A redirect from EX retargets fetch and discards stale in-flight responses.

## Interface
- XLEN, 32: PC and instruction width.
- DEPTH, 4: slot-queue entries; power of two, at least 2.
- MAX_OUT, 2: maximum in-flight memory requests, including ones being dropped; 1 to DEPTH.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-low reset; low = reset.
- redirect_valid  input  1  flush and retarget fetch this cycle.
- redirect_pc  input  XLEN  new fetch target.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  XLEN  fetch address.
- imem_rsp_valid  input  1  response valid; returned in request order and always accepted.
- imem_rsp_data  input  XLEN  instruction word.
- id_valid  output  1  head instruction available.
- id_ready  input  1  ID consumes the head.
- id_pc  output  XLEN  PC of the head.
- id_pc4  output  XLEN  id_pc + 4, modulo 2^XLEN.
- id_inst  output  XLEN  head instruction.
- perf_fetched  output  32  only with IF_PERF_CNT_EN.
- perf_dropped  output  32  only with IF_PERF_CNT_EN.

## Operation
- State:
  - fetch_pc
  - slot array of {pc, inst, filled}
  - alloc, fill and head pointers, log2(DEPTH)+1 bits each; the MSB distinguishes full from empty
  - out_cnt: live in-flight requests
  - drop_cnt: in-flight requests whose responses will be discarded
- Issue condition: slots_used < DEPTH, and out_cnt + drop_cnt < MAX_OUT, and no redirect this cycle.
  - imem_req_valid = issue condition; imem_req_addr = fetch_pc.
- Request handshake (valid & ready):
  - allocate a slot with pc = fetch_pc and filled = 0
  - fetch_pc += 4, wrapping
  - out_cnt++
- While valid & !ready, addr stays stable. The only exception is redirect, which may withdraw or retarget the request.
- Response handling:
  - If drop_cnt > 0: discard the response, drop_cnt--.
  - Otherwise: write inst into the slot at the fill pointer, set filled, advance fill, out_cnt--.
- id_valid = head slot filled & !redirect_valid.
- On id_valid & id_ready: pop the head, advance head.
- Redirect, highest priority:
  - fetch_pc <= redirect_pc
  - all slots invalidated; alloc, fill and head reset to 0
  - drop_cnt <= drop_cnt + out_cnt + (request handshake this cycle) − (response this cycle); out_cnt <= 0
  - an ID handshake in the redirect cycle is void
- Simultaneous request, response and pop in one cycle: all take effect; the counters net out.
- Reset mid-operation clears all state. Responses for requests issued before reset are the memory's responsibility; the memory is reset together with this block.

## Timing
- Reset values:
  - imem_req_valid 0, imem_req_addr RESET_PC
  - id_valid 0; id_pc, id_pc4 and id_inst 0
  - out_cnt and drop_cnt 0; perf counters 0
- First request is asserted in the first cycle after rst goes high, with addr RESET_PC.
- Response in cycle N: id_valid is asserted in cycle N+1 if that slot is the head. There is no combinational response-to-ID bypass.
- Redirect in cycle t: imem_req_valid at redirect_pc is asserted in t+1, provided the MAX_OUT budget allows.
- Full queue: no requests issue until a pop frees a slot. A freed slot is reusable in the cycle after the pop.
- Throughput with a zero-wait memory and id_ready held high: one instruction per cycle once MAX_OUT ≥ 2.

## Configuration
- IF_PERF_CNT_EN defined:
  - perf_fetched counts ID handshakes.
  - perf_dropped counts discarded responses.
  - Both are 32-bit, wrap, and reset to 0.
- IF_PERF_CNT_EN undefined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package if_pkg:
  - slot struct typedef {pc, inst, filled}
  - RESET_PC default
  - PC increment constant 4
- One sub-module, if_slot_queue: slot array with alloc, fill and pop pointers, the full/empty flags and the clear input. Fetch PC and counters stay in the top module.

## Test plan
- Reset release, zero-wait memory, id_ready=1: requests issue at 0x0, 0x4, 0x8…; id_pc sequence is 0x0, 0x4, 0x8; id_pc4 = 0x4, 0x8, 0xC.
- id_ready=0 with DEPTH=4: exactly 4 handshakes, then imem_req_valid stays 0. Raising id_ready for 1 cycle gives exactly 1 new request.
- Memory latency 3 with MAX_OUT=2: never more than 2 requests unanswered; every response maps to the correct PC.
- Redirect to 0x100 while 2 requests are in flight: drop_cnt=2, both responses discarded, first ID instruction has id_pc=0x100; perf_dropped=2 when IF_PERF_CNT_EN is defined.
- Redirect in the same cycle as a request handshake and a response: the accepted request is dropped and drop_cnt is correct; no stale instruction reaches ID.
- fetch_pc=0xFFFF_FFFC: the next address wraps to 0x0; id_pc4 = 0x0.
